// File: rtl/demux_edge_counter.sv
// Downstream sink for the 1-to-4 demux: per-channel saturating rising-edge counters,
// sticky overflow flags, most-recent-channel tracking and a req/ack count readback.
module demux_edge_counter #(
   parameter int unsigned CNT_W       = 8,
   parameter bit          CLR_ON_READ = 1'b1
) (
   input  logic             i_clk,
   input  logic             i_reset,
   input  logic [3:0]       i_ch_in,
   input  logic             i_clr,
   input  logic             i_rd_req,
   input  logic [1:0]       i_rd_sel,
   input  logic             i_rd_ack,
   output logic             o_rd_valid,
   output logic [CNT_W-1:0] o_rd_data,
   output logic [1:0]       o_rd_ch,
   output logic [3:0]       o_ovf,
   output logic [1:0]       o_last_ch
);

   localparam logic [0:0]       S_IDLE  = 1'b0;
   localparam logic [0:0]       S_RESP  = 1'b1;
   localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

   logic [0:0]       r_state;
   logic [0:0]       w_state_nxt;
   logic             w_snap_ld;
   logic             w_rd_clr;
   logic [3:0]       r_ch_q;
   logic [3:0]       w_rise;
   logic [1:0]       w_last_nxt;
   logic [CNT_W-1:0] r_cnt [4];
   logic [3:0]       r_ovf;
   logic [1:0]       r_last_ch;
   logic             r_rd_valid;
   logic [CNT_W-1:0] r_rd_data;
   logic [1:0]       r_rd_ch;

   assign w_rise = i_ch_in & ~r_ch_q;

   // Read handshake: snapshot on request in IDLE, release (and optionally clear) on ack.
   always_comb begin
      w_state_nxt = r_state;
      w_snap_ld   = 1'b0;
      w_rd_clr    = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (i_rd_req) begin
               w_state_nxt = S_RESP;
               w_snap_ld   = 1'b1;
            end
         end
         S_RESP: begin
            if (i_rd_ack) begin
               w_state_nxt = S_IDLE;
               w_rd_clr    = CLR_ON_READ;
            end
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   // Highest-index rising channel wins when several rise together.
   always_comb begin
      w_last_nxt = r_last_ch;
      for (int i = 0; i < 4; i++) begin
         if (w_rise[i]) w_last_nxt = 2'(i);
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_reset) r_state <= S_IDLE;
      else         r_state <= w_state_nxt;
   end

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_rd_valid <= 1'b0;
         r_rd_data  <= '0;
         r_rd_ch    <= 2'b00;
      end else begin
         r_rd_valid <= (w_state_nxt == S_RESP);
         if (w_snap_ld) begin
            r_rd_ch   <= i_rd_sel;
            r_rd_data <= i_clr ? '0 : r_cnt[i_rd_sel];
         end
      end
   end

   // Clear beats read-clear beats saturation beats increment.
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_ch_q    <= 4'b0000;
         r_ovf     <= 4'b0000;
         r_last_ch <= 2'b00;
         for (int i = 0; i < 4; i++) r_cnt[i] <= '0;
      end else begin
         r_ch_q    <= i_ch_in;
         r_last_ch <= w_last_nxt;
         for (int i = 0; i < 4; i++) begin
            if (i_clr) begin
               r_cnt[i] <= '0;
               r_ovf[i] <= 1'b0;
            end else if (w_rd_clr && (r_rd_ch == 2'(i))) begin
               r_cnt[i] <= w_rise[i] ? CNT_W'(1) : '0;
            end else if (w_rise[i]) begin
               if (r_cnt[i] == CNT_MAX) r_ovf[i] <= 1'b1;
               else                     r_cnt[i] <= r_cnt[i] + CNT_W'(1);
            end
         end
      end
   end

   assign o_rd_valid = r_rd_valid;
   assign o_rd_data  = r_rd_data;
   assign o_rd_ch    = r_rd_ch;
   assign o_ovf      = r_ovf;
   assign o_last_ch  = r_last_ch;

endmodule

// File: tb/tb_demux_edge_counter.sv
// Randomized + directed bench for demux_edge_counter; two instances (4-bit clear-on-read,
// 8-bit non-destructive) checked every cycle against a behavioural count model.
module tb_demux_edge_counter;

   logic       clk = 1'b0;
   logic       reset;
   logic [3:0] ch_in;
   logic       clr;
   logic       rd_req;
   logic [1:0] rd_sel;
   logic       rd_ack;

   logic       d0_valid, d1_valid;
   logic [3:0] d0_data;
   logic [7:0] d1_data;
   logic [1:0] d0_ch, d1_ch, d0_last, d1_last;
   logic [3:0] d0_ovf, d1_ovf;

   int n_checks = 0;
   int n_errors = 0;

   // Model state, index 0 = 4-bit clear-on-read, index 1 = 8-bit non-destructive.
   int         m_cnt  [2][4];
   bit   [3:0] m_ovf  [2];
   int         m_last [2];
   bit         m_busy [2];
   int         m_data [2];
   int         m_ch   [2];
   bit   [3:0] m_prev;

   demux_edge_counter #(.CNT_W(4), .CLR_ON_READ(1'b1)) u_dut0 (
      .i_clk(clk), .i_reset(reset), .i_ch_in(ch_in), .i_clr(clr),
      .i_rd_req(rd_req), .i_rd_sel(rd_sel), .i_rd_ack(rd_ack),
      .o_rd_valid(d0_valid), .o_rd_data(d0_data), .o_rd_ch(d0_ch),
      .o_ovf(d0_ovf), .o_last_ch(d0_last));

   demux_edge_counter #(.CNT_W(8), .CLR_ON_READ(1'b0)) u_dut1 (
      .i_clk(clk), .i_reset(reset), .i_ch_in(ch_in), .i_clr(clr),
      .i_rd_req(rd_req), .i_rd_sel(rd_sel), .i_rd_ack(rd_ack),
      .o_rd_valid(d1_valid), .o_rd_data(d1_data), .o_rd_ch(d1_ch),
      .o_ovf(d1_ovf), .o_last_ch(d1_last));

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s got=%0d expected=%0d (t=%0t)", tag, got, exp, $time);
      end
   endtask

   function automatic void model_step();
      bit [3:0] rise;
      int       rc;
      int       mx;
      rise = ch_in & ~m_prev;
      for (int k = 0; k < 2; k++) begin
         mx = (k == 0) ? 15 : 255;
         if (reset) begin
            for (int i = 0; i < 4; i++) m_cnt[k][i] = 0;
            m_ovf[k] = '0; m_last[k] = 0; m_busy[k] = 0; m_data[k] = 0; m_ch[k] = 0;
         end else begin
            rc = (m_busy[k] && rd_ack && k == 0) ? m_ch[k] : -1;
            if (!m_busy[k]) begin
               if (rd_req) begin
                  m_data[k] = clr ? 0 : m_cnt[k][rd_sel];
                  m_ch[k]   = int'(rd_sel);
                  m_busy[k] = 1;
               end
            end else if (rd_ack) begin
               m_busy[k] = 0;
            end
            for (int i = 0; i < 4; i++) begin
               if (clr) begin
                  m_cnt[k][i] = 0; m_ovf[k][i] = 0;
               end else if (i == rc) begin
                  m_cnt[k][i] = rise[i] ? 1 : 0;
               end else if (rise[i]) begin
                  if (m_cnt[k][i] == mx) m_ovf[k][i] = 1;
                  else                   m_cnt[k][i]++;
               end
               if (rise[i]) m_last[k] = i;
            end
         end
      end
      m_prev = reset ? 4'b0000 : ch_in;
   endfunction

   task automatic compare_all();
      check("valid0", 32'(d0_valid), 32'(m_busy[0]));
      check("data0",  32'(d0_data),  m_data[0]);
      check("ch0",    32'(d0_ch),    m_ch[0]);
      check("ovf0",   32'(d0_ovf),   32'(m_ovf[0]));
      check("last0",  32'(d0_last),  m_last[0]);
      check("valid1", 32'(d1_valid), 32'(m_busy[1]));
      check("data1",  32'(d1_data),  m_data[1]);
      check("ch1",    32'(d1_ch),    m_ch[1]);
      check("ovf1",   32'(d1_ovf),   32'(m_ovf[1]));
      check("last1",  32'(d1_last),  m_last[1]);
   endtask

   task automatic tick();
      @(posedge clk);
      model_step();
      #1;
      compare_all();
   endtask

   task automatic do_read(input logic [1:0] sel, input int exp0, input int exp1);
      rd_req = 1'b1; rd_sel = sel;
      tick();
      rd_req = 1'b0;
      check("rd_valid0", 32'(d0_valid), 1);
      check("rd_valid1", 32'(d1_valid), 1);
      check("rd_data0",  32'(d0_data), exp0);
      check("rd_data1",  32'(d1_data), exp1);
      rd_ack = 1'b1;
      tick();
      rd_ack = 1'b0;
   endtask

   task automatic pulse_clr();
      clr = 1'b1; tick(); clr = 1'b0;
   endtask

   task automatic toggle(input logic [3:0] mask, input int n);
      for (int i = 0; i < n; i++) begin
         ch_in = (i % 2 == 1) ? mask : 4'b0000;
         tick();
      end
      ch_in = 4'b0000;
      tick();
   endtask

   initial begin
      reset = 1'b1; ch_in = '0; clr = 1'b0; rd_req = 1'b0; rd_sel = '0; rd_ack = 1'b0;
      m_prev = '0;
      for (int k = 0; k < 2; k++) begin
         for (int i = 0; i < 4; i++) m_cnt[k][i] = 0;
         m_ovf[k] = '0; m_last[k] = 0; m_busy[k] = 0; m_data[k] = 0; m_ch[k] = 0;
      end

      // Reset held with ch_in toggling
      for (int i = 0; i < 3; i++) begin
         ch_in = ~ch_in;
         tick();
      end
      ch_in = 4'b0000;
      tick();
      reset = 1'b0;
      check("rst_valid", 32'(d0_valid), 0);
      check("rst_ovf",   32'(d0_ovf),   0);
      check("rst_last",  32'(d0_last),  0);
      check("rst_data",  32'(d0_data),  0);
      tick();

      // Demux select=01: 20 cycles of toggling gives 10 edges on ch1
      toggle(4'b0010, 20);
      check("t2_last", 32'(d0_last), 1);
      do_read(2'd1, 10, 10);
      do_read(2'd0, 0, 0);
      do_read(2'd2, 0, 0);
      do_read(2'd3, 0, 0);

      // Saturation on ch2 in the 4-bit instance
      pulse_clr();
      toggle(4'b0100, 34);
      check("t3_ovf0", 32'(d0_ovf), 32'h4);
      check("t3_ovf1", 32'(d1_ovf), 32'h0);
      do_read(2'd2, 15, 17);
      check("t3_ovf_sticky", 32'(d0_ovf), 32'h4);
      pulse_clr();
      check("t3_ovf_clr", 32'(d0_ovf), 32'h0);
      do_read(2'd2, 0, 0);

      // Rise on ch3 during the ack cycle survives the read-clear
      pulse_clr();
      toggle(4'b1000, 10);
      rd_req = 1'b1; rd_sel = 2'd3;
      tick();
      rd_req = 1'b0;
      check("t4_data0", 32'(d0_data), 5);
      ch_in = 4'b1000; rd_ack = 1'b1;
      tick();
      rd_ack = 1'b0; ch_in = 4'b0000;
      tick();
      do_read(2'd3, 1, 6);

      // Rise on the selected channel in the request cycle is excluded from the snapshot
      pulse_clr();
      toggle(4'b0001, 14);
      rd_req = 1'b1; rd_sel = 2'd0; ch_in = 4'b0001;
      tick();
      rd_req = 1'b0; ch_in = 4'b0000;
      check("t5_data0", 32'(d0_data), 7);
      check("t5_data1", 32'(d1_data), 7);
      rd_ack = 1'b1;
      tick();
      rd_ack = 1'b0;
      do_read(2'd0, 0, 8);

      // Reset aborts an in-progress read
      rd_req = 1'b1; rd_sel = 2'd0;
      tick();
      rd_req = 1'b0;
      check("t6_valid_pre", 32'(d1_valid), 1);
      reset = 1'b1; rd_ack = 1'b1;
      tick();
      reset = 1'b0; rd_ack = 1'b0;
      check("t6_valid0", 32'(d0_valid), 0);
      check("t6_valid1", 32'(d1_valid), 0);
      tick();
      do_read(2'd0, 0, 0);
      do_read(2'd3, 0, 0);

      // Randomized traffic against the model
      for (int c = 0; c < 800; c++) begin
         ch_in  = 4'($urandom);
         clr    = ($urandom_range(0, 31) == 0);
         rd_req = ($urandom_range(0, 2) == 0);
         rd_sel = 2'($urandom);
         rd_ack = ($urandom_range(0, 1) == 0);
         reset  = ($urandom_range(0, 149) == 0);
         tick();
      end

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
